cache_2way_ctrl: RTL

- Blocking FSM controller that sequences the 2-way set-associative cache data/tag array.
- Sits between the CPU load/store port and a 128-bit line-wide memory port.
- Holds the valid, dirty and LRU state for every set. Drives all array write controls.
- Write-back, write-allocate. Handles hit compare, victim selection, dirty writeback and line refill.

---
 rtl/cache_2way_ctrl_if.sv | 54 +++++
 rtl/cache_2way_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_2way_ctrl_if.sv
// CPU, memory and tag/data array signal bundle for the 2-way cache controller.
// master = controller side, slave = CPU/memory/array environment side.
interface cache_2way_ctrl_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int TAG_BITS   = 23
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [31:0]           cpu_addr;
  logic [31:0]           cpu_wdata;
  logic [3:0]            cpu_byte_en;
  logic                  cpu_ready;
  logic [31:0]           cpu_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [31:0]           mem_addr;
  logic [127:0]          mem_wdata;
  logic [127:0]          mem_rdata;
  logic                  mem_ack;

  logic                  arr_wr_en;
  logic                  arr_wr_tag_en;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [1:0]            arr_way_select;
  logic [127:0]          arr_wr_data;
  logic [TAG_BITS-1:0]   arr_wr_tag;
  logic [3:0]            arr_wr_word_en;
  logic [3:0]            arr_wr_byte_en;
  logic [TAG_BITS-1:0]   tag_way0;
  logic [TAG_BITS-1:0]   tag_way1;
  logic [127:0]          rd_way0;
  logic [127:0]          rd_way1;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_byte_en,
    input  mem_rdata, mem_ack,
    input  tag_way0, tag_way1, rd_way0, rd_way1,
    output cpu_ready, cpu_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output arr_wr_en, arr_wr_tag_en, arr_addr, arr_way_select,
    output arr_wr_data, arr_wr_tag, arr_wr_word_en, arr_wr_byte_en
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_byte_en,
    output mem_rdata, mem_ack,
    output tag_way0, tag_way1, rd_way0, rd_way1,
    input  cpu_ready, cpu_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  arr_wr_en, arr_wr_tag_en, arr_addr, arr_way_select,
    input  arr_wr_data, arr_wr_tag, arr_wr_word_en, arr_wr_byte_en
  );
endinterface

// File: rtl/cache_2way_ctrl.sv
// Blocking write-back/write-allocate controller for a 2-way set-associative cache.
// Define CACHE_STATS_EN to add hit_cnt/miss_cnt counter outputs.
module cache_2way_ctrl #(
  parameter int ADDR_WIDTH       = 5,
  parameter int TAG_BITS         = 23,
  parameter int WHOLE_DATA_WIDTH = 128,
  parameter int BANK_DATA_WIDTH  = 32,
  parameter int DATA_WORD_NUM    = 4,
  parameter int DATA_BYTE_NUM    = 4,
  parameter int CACHE_WAY_NUM    = 2
) (
  input  logic clk,
  input  logic rst,
  cache_2way_ctrl_if.master bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int SETS = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE, COMPARE, WRITEBACK, REFILL
  } state_e;

  state_e           state_q, state_d;
  logic [31:2]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic [SETS-1:0]  v0_q, v0_d, v1_q, v1_d;
  logic [SETS-1:0]  d0_q, d0_d, d1_q, d1_d;
  logic [SETS-1:0]  lru_q, lru_d;
  logic             vic_q, vic_d;

  logic [ADDR_WIDTH-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic [1:0]            word;
  logic                  hit0, hit1, hit, hit_way;
  logic [3:0][31:0]      hit_words;
  logic [127:0]          vic_line;
  logic [TAG_BITS-1:0]   vic_tag;
  logic                  vsel, vsel_dirty;

  assign idx  = addr_q[ADDR_WIDTH+3:4];
  assign tag  = addr_q[31:32-TAG_BITS];
  assign word = addr_q[3:2];

  assign hit0    = v0_q[idx] && (bus.tag_way0 == tag);
  assign hit1    = v1_q[idx] && (bus.tag_way1 == tag);
  assign hit     = hit0 || hit1;
  assign hit_way = !hit0;
  assign hit_words = hit0 ? bus.rd_way0 : bus.rd_way1;

  assign vic_line = vic_q ? bus.rd_way1 : bus.rd_way0;
  assign vic_tag  = vic_q ? bus.tag_way1 : bus.tag_way0;

  // Fill empty ways first; LRU only decides once both ways hold lines.
  assign vsel = !v0_q[idx] ? 1'b0 :
                !v1_q[idx] ? 1'b1 : lru_q[idx];
  assign vsel_dirty = vsel ? (v1_q[idx] && d1_q[idx])
                           : (v0_q[idx] && d0_q[idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      v0_q    <= '0;
      v1_q    <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
      lru_q   <= '0;
      vic_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      lru_q   <= lru_d;
      vic_q   <= vic_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    lru_d   = lru_q;
    vic_d   = vic_q;

    bus.cpu_ready      = 1'b0;
    bus.cpu_rdata      = '0;
    bus.mem_req        = 1'b0;
    bus.mem_we         = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_wdata      = '0;
    bus.arr_wr_en      = 1'b0;
    bus.arr_wr_tag_en  = 1'b0;
    bus.arr_addr       = idx;
    bus.arr_way_select = 2'b00;
    bus.arr_wr_data    = '0;
    bus.arr_wr_tag     = '0;
    bus.arr_wr_word_en = 4'b0000;
    bus.arr_wr_byte_en = 4'b0000;

    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr[31:2];
          we_d    = bus.cpu_we;
          wdata_d = bus.cpu_wdata;
          be_d    = bus.cpu_byte_en;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          bus.cpu_ready = 1'b1;
          lru_d[idx]    = ~hit_way;
          state_d       = IDLE;
          if (we_q) begin
            bus.arr_wr_en      = 1'b1;
            bus.arr_way_select = hit_way ? 2'b10 : 2'b01;
            bus.arr_wr_word_en = 4'b0001 << word;
            bus.arr_wr_byte_en = be_q;
            bus.arr_wr_data    = {4{wdata_q}};
            if (hit_way) d1_d[idx] = 1'b1;
            else         d0_d[idx] = 1'b1;
          end else begin
            bus.cpu_rdata = hit_words[word];
          end
        end else begin
          vic_d   = vsel;
          state_d = vsel_dirty ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {vic_tag, idx, 4'b0000};
        bus.mem_wdata = vic_line;
        if (bus.mem_ack) state_d = REFILL;
      end
      REFILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {tag, idx, 4'b0000};
        if (bus.mem_ack) begin
          bus.arr_wr_en      = 1'b1;
          bus.arr_wr_tag_en  = 1'b1;
          bus.arr_way_select = vic_q ? 2'b10 : 2'b01;
          bus.arr_wr_word_en = 4'b1111;
          bus.arr_wr_byte_en = 4'b1111;
          bus.arr_wr_data    = bus.mem_rdata;
          bus.arr_wr_tag     = tag;
          if (vic_q) begin
            v1_d[idx] = 1'b1;
            d1_d[idx] = 1'b0;
          end else begin
            v0_d[idx] = 1'b1;
            d0_d[idx] = 1'b0;
          end
          state_d = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CACHE_STATS_EN
  logic retry_q;

  // The compare after a refill is the tail of a miss, not a new hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      retry_q  <= 1'b0;
    end else begin
      if (state_q == REFILL && bus.mem_ack) retry_q <= 1'b1;
      else if (state_q == COMPARE)          retry_q <= 1'b0;
      if (state_q == COMPARE) begin
        if (hit && !retry_q) hit_cnt  <= hit_cnt + 32'd1;
        if (!hit)            miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif
endmodule
